// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI master controller.
package spi_pkg;

  // Controller phases: idle, cs_n setup, bit shifting, cs_n hold.
  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} spi_state_t;

  localparam int SPI_DATA_W  = 8;
  localparam int SPI_CLK_DIV = 4;

  // Clk cycles from the accepting edge to the done edge:
  // one setup tick, 2*data_w sclk half-periods, one hold tick.
  function automatic int xfer_cycles(input int data_w, input int clk_div);
    return (2 * data_w + 2) * clk_div;
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Free-running divider that emits a one-cycle tick every CLK_DIV cycles while enabled.
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  // Count 0..CLK_DIV-1 while enabled; clear whenever disabled so each transfer starts aligned.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (!en) begin
      cnt <= '0;
    end else if (cnt == TERM) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = en && (cnt == TERM);

endmodule

// File: rtl/spi_master_ctrl.sv
// Mode-0 SPI master: one DATA_W-bit full-duplex transfer per accepted start.
//
// Handshake: start is a request that is accepted on any rising clk edge where
// start=1 and busy=0 (i.e. the controller is IDLE). busy then stays high until
// the edge that raises done; requests seen while busy=1 are dropped, not queued.
// done is a one-cycle strobe, and the controller is already IDLE in that cycle,
// so a start held high is accepted immediately (back-to-back transfers).
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int DATA_W  = SPI_DATA_W,
  parameter int CLK_DIV = SPI_CLK_DIV
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              done,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic              cs_n
);

  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W);

  // Current phase; kept as a named signal so checkers can bind to it.
  spi_state_t state;
  spi_state_t next_state;

  logic              tick;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] rx_shift;
  logic [BW-1:0]     bit_cnt;

  // Per-edge action strobes decoded from state and divider tick.
  logic accept;
  logic rise;
  logic shift;
  logic last_fall;
  logic finish;

  spi_clk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_div (
    .clk (clk),
    .rstn(rstn),
    .en  (state != IDLE),
    .tick(tick)
  );

  // The outgoing bit is always the MSB of the transmit shifter, so loading,
  // shifting and clearing it also drives mosi.
  assign mosi = tx_shift[DATA_W-1];

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and action decode; each tick in XFER is one sclk toggle.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    rise       = 1'b0;
    shift      = 1'b0;
    last_fall  = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          next_state = SETUP;
        end
      end
      SETUP: begin
        if (tick) begin
          next_state = XFER;
        end
      end
      XFER: begin
        if (tick) begin
          if (!sclk) begin
            rise = 1'b1;
          end else if (bit_cnt < LAST_BIT) begin
            shift = 1'b1;
          end else begin
            last_fall  = 1'b1;
            next_state = HOLD;
          end
        end
      end
      HOLD: begin
        if (tick) begin
          finish     = 1'b1;
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Datapath and pin registers driven by the decoded strobes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_shift <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      bit_cnt  <= '0;
      sclk     <= 1'b0;
      cs_n     <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        tx_shift <= tx_data;
        cs_n     <= 1'b0;
        busy     <= 1'b1;
        bit_cnt  <= '0;
      end
      if (rise) begin
        // miso is taken at the edge that raises sclk.
        sclk     <= 1'b1;
        rx_shift <= {rx_shift[DATA_W-2:0], miso};
        bit_cnt  <= bit_cnt + BW'(1);
      end
      if (shift) begin
        sclk     <= 1'b0;
        tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
      end
      if (last_fall) begin
        // mosi keeps the last bit through the hold phase.
        sclk <= 1'b0;
      end
      if (finish) begin
        cs_n     <= 1'b1;
        rx_data  <= rx_shift;
        done     <= 1'b1;
        busy     <= 1'b0;
        tx_shift <= '0;
      end
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl against a transfer-level reference model.
module tb_spi_master_ctrl;
  import spi_pkg::*;

  localparam int W   = SPI_DATA_W;
  localparam int DIV = SPI_CLK_DIV;
  localparam int LAT = xfer_cycles(SPI_DATA_W, SPI_CLK_DIV);

  // ---------------- clock / reset ----------------
  logic         clk  = 1'b0;
  logic         rstn = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] tx_data = '0;
  logic [W-1:0] rx_data;
  logic         busy, done, sclk, mosi, miso, cs_n;

  always #5 clk = ~clk;

  spi_master_ctrl #(
    .DATA_W (W),
    .CLK_DIV(DIV)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .start  (start),
    .tx_data(tx_data),
    .rx_data(rx_data),
    .busy   (busy),
    .done   (done),
    .sclk   (sclk),
    .mosi   (mosi),
    .miso   (miso),
    .cs_n   (cs_n)
  );

  // ---------------- scoreboard state ----------------
  typedef struct {
    logic [W-1:0] tx;
    logic [W-1:0] pat;
    bit           lb;
  } req_t;

  req_t         req_q[$];
  logic [W-1:0] exp_q[$];
  int           done_cyc_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- slave model: miso source ----------------
  // Non-loopback transfers present the pattern MSB first, one bit per sclk
  // period, changing right after each sclk rise.
  bit           cur_lb  = 1'b0;
  logic [W-1:0] cur_tx  = '0;
  logic [W-1:0] cur_pat = '0;
  logic         pat_bit = 1'b0;

  assign miso = cur_lb ? mosi : pat_bit;

  // ---------------- monitor ----------------
  int           cyc = 0, acc_cyc = 0;
  int           rises, falls, cs_low, busy_hi, hi_len, lo_len;
  int           phase_err, mosi_err, hold_err = 0, done_cnt = 0;
  int           cs_hi_run = 0, last_gap = 0;
  bit           in_xfer = 0, prev_sclk = 0, prev_busy = 0, chk_width = 0;
  logic [W-1:0] model_rx = '0;
  logic [W-1:0] exp_word;
  req_t         mon_req;

  // Observes pins once per cycle and scores each transfer when done appears.
  always @(negedge clk) begin
    cyc++;
    if (!rstn) begin
      in_xfer   = 0;
      prev_busy = 0;
      prev_sclk = 0;
      chk_width = 0;
      cs_hi_run = 0;
      pat_bit   = 1'b0;
      model_rx  = '0;
    end else begin
      if (chk_width) begin
        check("done_width", done, 1'b0);
        chk_width = 0;
      end
      if (busy && !prev_busy) begin
        if (req_q.size() == 0) begin
          check("unexpected_accept", 1, 0);
        end else begin
          mon_req = req_q.pop_front();
          cur_tx  = mon_req.tx;
          cur_pat = mon_req.pat;
          cur_lb  = mon_req.lb;
        end
        in_xfer   = 1;
        acc_cyc   = cyc;
        rises     = 0;
        falls     = 0;
        cs_low    = 0;
        busy_hi   = 0;
        hi_len    = 0;
        lo_len    = 0;
        phase_err = 0;
        mosi_err  = 0;
        last_gap  = cs_hi_run;
      end
      if (in_xfer) begin
        if (busy) busy_hi++;
        if (!cs_n) cs_low++;
        if (sclk && !prev_sclk) begin
          if (rises > 0 && lo_len != DIV) phase_err++;
          rises++;
          hi_len = 0;
        end
        if (!sclk && prev_sclk) begin
          if (hi_len != DIV) phase_err++;
          falls++;
          lo_len = 0;
        end
        if (sclk) hi_len++;
        else lo_len++;
        if (busy && falls < W && mosi !== cur_tx[W-1-falls]) mosi_err++;
      end
      if (done) begin
        done_cnt++;
        done_cyc_q.push_back(cyc);
        chk_width = 1;
        if (!in_xfer) begin
          check("done_without_xfer", 1, 0);
        end else begin
          check("latency", cyc - acc_cyc, LAT);
          check("sclk_rises", rises, W);
          check("cs_low_cycles", cs_low, LAT);
          check("busy_cycles", busy_hi, LAT);
          check("sclk_phase_errs", phase_err, 0);
          check("mosi_bit_errs", mosi_err, 0);
          check("idle_pins_busy_csn_sclk_mosi", {busy, cs_n, sclk, mosi}, 4'b0100);
          if (exp_q.size() == 0) begin
            check("exp_q_underflow", 1, 0);
          end else begin
            exp_word = exp_q.pop_front();
            check("rx_data", rx_data, exp_word);
            model_rx = exp_word;
          end
        end
        in_xfer = 0;
      end else if (rx_data !== model_rx) begin
        hold_err++;
      end
      if (cs_n) cs_hi_run++;
      else cs_hi_run = 0;
      pat_bit   = (rises < W) ? cur_pat[W-1-rises] : 1'b0;
      prev_sclk = sclk;
      prev_busy = busy;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int n = 0;
    while (busy && n < LAT + 40) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", busy, 1'b0);
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < LAT + 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("done_count", done_cnt, target);
  endtask

  task automatic queue_req(input logic [W-1:0] tx, input bit lb, input logic [W-1:0] pat);
    req_t r;
    r.tx  = tx;
    r.pat = pat;
    r.lb  = lb;
    req_q.push_back(r);
    exp_q.push_back(lb ? tx : pat);
  endtask

  // One transfer; optionally pulses start twice mid-transfer to show it is ignored.
  task automatic xfer(input logic [W-1:0] tx, input bit lb, input logic [W-1:0] pat,
                      input bit ign);
    int base;
    wait_idle();
    @(negedge clk);
    #1;
    base = done_cnt;
    queue_req(tx, lb, pat);
    tx_data = tx;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    tx_data = W'($urandom);
    if (ign) begin
      repeat (9) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (29) @(negedge clk);
      start = 1'b1;
      tx_data = W'($urandom);
      @(negedge clk);
      start = 1'b0;
    end
    wait_done(base + 1);
    repeat (4) @(negedge clk);
    #1;
    check("single_done", done_cnt, base + 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int base;
    #2 rstn = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_sclk", sclk, 1'b0);
    check("rst_cs_n", cs_n, 1'b1);
    check("rst_mosi", mosi, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_rx_data", rx_data, '0);
    @(negedge clk);
    rstn = 1'b1;

    // Directed patterns: loopback, all-ones/all-zeros miso, bit order.
    xfer(8'hA5, 1'b1, 8'h00, 1'b0);
    xfer(8'h00, 1'b0, 8'hFF, 1'b0);
    xfer(8'hFF, 1'b0, 8'h00, 1'b0);
    xfer(8'h80, 1'b0, 8'h01, 1'b0);

    // Starts during an active transfer are dropped.
    xfer(8'h5A, 1'b1, 8'h00, 1'b1);

    // Back-to-back with start held high; tx_data changes while busy.
    wait_idle();
    @(negedge clk);
    #1;
    base = done_cnt;
    queue_req(8'h3C, 1'b1, 8'h00);
    queue_req(8'hC3, 1'b1, 8'h00);
    tx_data = 8'h3C;
    start   = 1'b1;
    @(negedge clk);
    tx_data = 8'hC3;
    wait_done(base + 1);
    @(negedge clk);
    start = 1'b0;
    wait_done(base + 2);
    check("b2b_cs_high_gap", last_gap, 1);
    check("b2b_done_spacing", done_cyc_q[$] - done_cyc_q[$-1], LAT + 1);

    // Randomized transfers.
    for (int i = 0; i < 6; i++) begin
      xfer(W'($urandom), 1'($urandom_range(0, 1)), W'($urandom), 1'b0);
    end

    // Reset in the middle of a transfer after a known nonzero result.
    xfer(8'hA5, 1'b1, 8'h00, 1'b0);
    wait_idle();
    @(negedge clk);
    #1;
    queue_req(8'h96, 1'b1, 8'h00);
    tx_data = 8'h96;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(negedge clk);
    base = done_cnt;
    #2 rstn = 1'b0;
    #1;
    check("midrst_sclk", sclk, 1'b0);
    check("midrst_cs_n", cs_n, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_rx_data", rx_data, '0);
    check("midrst_mosi", mosi, 1'b0);
    exp_q.delete();
    req_q.delete();
    repeat (3) @(negedge clk);
    #1;
    check("midrst_no_done", done_cnt, base);
    @(negedge clk);
    rstn = 1'b1;
    xfer(8'h69, 1'b1, 8'h00, 1'b0);

    repeat (5) @(negedge clk);
    check("rx_hold_errs", hold_err, 0);
    check("req_q_drained", req_q.size(), 0);
    check("exp_q_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish before %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
Single-channel SPI master controller, mode 0 (CPOL=0, CPHA=0). It sequences one DATA_W-bit full-duplex transfer per accepted start request. It generates sclk from the system clock, drives cs_n and mosi, samples miso, and returns the received word with a one-cycle done strobe. It sits between the register/host side and the SPI pins, and drives the sclk that slave-side logic edge-detects.

Parameters:
DATA_W, 8, bits per transfer, MSB first; legal range >= 2.
CLK_DIV, 4, clk cycles per sclk half-period; also the cs_n setup and hold time; legal range >= 2.

Ports:
clk  input  1  system clock; all logic on its rising edge.
rstn  input  1  asynchronous, active-low reset.
start  input  1  transfer request; sampled only while busy=0.
tx_data  input  DATA_W  word to send; captured on the accepting edge.
rx_data  output  DATA_W  last received word; updated on the done edge; holds otherwise.
busy  output  1  high from the accepting edge until the done edge.
done  output  1  one-cycle pulse when a transfer completes.
sclk  output  1  SPI clock; idles low.
mosi  output  1  serial data out.
miso  input  1  serial data in; synchronous to sclk, no synchroniser inside.
cs_n  output  1  active-low chip select; idles high.

Behaviour:
- Reset (async, rstn=0): state=IDLE, sclk=0, cs_n=1, mosi=0, busy=0, done=0, rx_data=0, shift registers, bit counter and divider counter all 0.
- States (shared enum): IDLE, SETUP, XFER, HOLD.
- IDLE, start=1 at edge E0: tx_shift<=tx_data, mosi<=tx_data[DATA_W-1], cs_n<=0, busy<=1, bit_cnt<=0, div_cnt<=0, go to SETUP.
- Divider: in SETUP/XFER/HOLD, div_cnt counts 0..CLK_DIV-1 and wraps. The terminal count (div_cnt=CLK_DIV-1) is a tick.
- SETUP: sclk stays 0. On the first tick, go to XFER. The first sclk rise is on the next tick.
- XFER, each tick toggles sclk:
  - Rising toggle (0->1): rx_shift<={rx_shift[DATA_W-2:0], miso}; bit_cnt++.
  - Falling toggle (1->0) with bit_cnt<DATA_W: shift tx_shift left; mosi<=new MSB.
  - Falling toggle with bit_cnt==DATA_W: mosi holds its value; go to HOLD.
- HOLD: sclk=0, cs_n=0. On the tick: cs_n<=1, rx_data<=rx_shift, done<=1, busy<=0, mosi<=0, go to IDLE.
- Timing: done, cs_n rise and busy fall all occur on edge E0+(2*DATA_W+2)*CLK_DIV. This is 72 clk cycles for the defaults.
- sclk has exactly DATA_W rising edges per transfer. The high and low phases are each CLK_DIV cycles.
- done is high for exactly one cycle. State is IDLE during that cycle, so a start sampled in the done cycle is accepted (back-to-back transfer, cs_n high for exactly 1 cycle).
- start while busy=1: ignored, no queueing. tx_data changes while busy have no effect.
- rstn low mid-transfer: immediate return to reset values, no done pulse, rx_data cleared to 0.
- miso is sampled at the clk edge that drives sclk high, i.e. the value present in the cycle before the sclk rise.

Decomposition:
- Shared package spi_pkg holds:
  - typedef enum logic [1:0] spi_state_t {IDLE, SETUP, XFER, HOLD};
  - localparam defaults SPI_DATA_W=8 and SPI_CLK_DIV=4;
  - function xfer_cycles(data_w, clk_div) returning (2*data_w+2)*clk_div, for use by benches.
- One sub-module, spi_clk_div. Inputs: clk, rstn, en. Output: tick. Parameter: CLK_DIV. Its counter clears when en=0. The controller enables it in every non-IDLE state.

Test Plan:
- Loopback (miso=mosi), DATA_W=8, CLK_DIV=4, tx_data=8'hA5, single start -> rx_data=8'hA5 and done pulses exactly 72 cycles after the accepting edge; 8 sclk rises; cs_n low for 72 cycles; busy high 72 cycles.
- miso tied 1, tx_data=8'h00 -> rx_data=8'hFF, mosi=0 throughout; with miso tied 0 and tx_data=8'hFF -> rx_data=8'h00, mosi high from E0 through the last sclk fall.
- Bit order check, tx_data=8'h80, loopback off, miso driven from an 8'h01 pattern (MSB first) -> mosi high only in the first bit window; rx_data=8'h01.
- start pulsed at cycles 10 and 40 of an active transfer -> ignored: exactly one done, 72 cycles after the first accept.
- Back-to-back: start held high continuously, tx_data 8'h3C then 8'hC3 -> two transfers; cs_n high exactly 1 cycle between them; done at cycles 72 and 145; rx_data matches in loopback.
- rstn driven low at cycle 30 of a transfer -> sclk=0, cs_n=1, busy=0, rx_data=0 asynchronously; no done; a new start after reset gives a correct 72-cycle transfer.
